data_mem_ctrl: RTL and testbench

//  MEM-stage data-memory controller. Sits between the CPU's EX/MEM register and a

---
 rtl/dmc_pkg.sv | 13 +
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/dmc_wbuf.sv | 50 +++++
 rtl/data_mem_ctrl.sv | 134 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmc_pkg.sv
// Shared types and width defaults for the MEM-stage data-memory controller.
package dmc_pkg;

  localparam int DMC_ADDR_W = 32;
  localparam int DMC_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } dmc_state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/acknowledge bus between the data-memory controller and the backing memory.
// Signal names keep the controller-side _o/_i suffixes so both ends read the same.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = dmc_pkg::DMC_ADDR_W,
  parameter int DATA_W = dmc_pkg::DMC_DATA_W
) ();

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dmc_wbuf.sv
// One-entry posted write buffer (address, data, valid) used only when WRITE_BUFFER_EN
// is defined; push and pop never coincide because a push needs an empty entry.
module dmc_wbuf #(
  parameter int ADDR_W = dmc_pkg::DMC_ADDR_W,
  parameter int DATA_W = dmc_pkg::DMC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop_i) valid_d = 1'b0;
    if (push_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: turns MemRead/MemWrite strobes into req/ack
// transactions and stalls the pipeline until each completes. WRITE_BUFFER_EN adds a posted store.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int ADDR_W = DMC_ADDR_W,
  parameter int DATA_W = DMC_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [ADDR_W-1:0] Address_i,
  input  logic [DATA_W-1:0] Writedata_i,
  output logic [DATA_W-1:0] Readdata_o,
  output logic              stall_o,
  data_mem_ctrl_if.master   mem
);

  dmc_state_t        state_q, state_d;
  logic              req_q,   req_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              access;

  assign access = MemRead_i | MemWrite_i;

`ifdef WRITE_BUFFER_EN
  logic              wb_valid, wb_push, wb_pop;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // The buffer only holds a store while the main FSM sits in IDLE, so any ack seen then is its own.
  assign wb_pop = wb_valid & mem.mem_ack_i;

  dmc_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (wb_push),
    .pop_i   (wb_pop),
    .addr_i  (Address_i),
    .data_i  (Writedata_i),
    .valid_o (wb_valid),
    .addr_o  (wb_addr),
    .data_o  (wb_data)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stall_o = 1'b0;
`ifdef WRITE_BUFFER_EN
    wb_push = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        stall_o = access;
`ifdef WRITE_BUFFER_EN
        // A draining store holds every new access here until its ack frees the bus.
        if (!wb_valid && MemWrite_i) begin
          stall_o = 1'b0;
          wb_push = 1'b1;
        end else if (!wb_valid && MemRead_i) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = Address_i;
          state_d = BUSY;
        end
`else
        if (access) begin
          req_d   = 1'b1;
          we_d    = MemWrite_i;
          addr_d  = Address_i;
          wdata_d = Writedata_i;
          state_d = BUSY;
        end
`endif
      end
      BUSY: begin
        stall_o = 1'b1;
        if (mem.mem_ack_i) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = mem.mem_rdata_i;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      // NOTE: datapath registers are reset as well so Readdata_o and the bus read 0 after reset.
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign Readdata_o = rdata_q;

`ifdef WRITE_BUFFER_EN
  assign mem.mem_req_o   = req_q | wb_valid;
  assign mem.mem_we_o    = we_q  | wb_valid;
  assign mem.mem_addr_o  = wb_valid ? wb_addr : addr_q;
  assign mem.mem_wdata_o = wb_valid ? wb_data : wdata_q;
`else
  assign mem.mem_req_o   = req_q;
  assign mem.mem_we_o    = we_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed reset/corner cases then random loads and stores,
// with a latency-programmable memory responder and a queue-based scoreboard.
module tb_data_mem_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            stall;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          MemRead_i, MemWrite_i;
  logic [AW-1:0] Address_i;
  logic [DW-1:0] Writedata_i;
  logic [DW-1:0] Readdata_o;
  logic          stall_o;

  data_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  data_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .Address_i   (Address_i),
    .Writedata_i (Writedata_i),
    .Readdata_o  (Readdata_o),
    .stall_o     (stall_o),
    .mem         (mem_bus.master)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  exp_t          exp_q[$];
  int            lat_q[$];
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] bk_mem[logic [AW-1:0]];
  logic [DW-1:0] last_rd = '0;
  bit            auto_en = 1'b0;
  bit            mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Unwritten locations return an address-derived pattern.
  function automatic logic [DW-1:0] blank(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : blank(a);
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ref_mem[a] = d;
    bk_mem[a]  = d;
  endtask

  // Backing memory: acks on the Nth cycle of each request, N taken from lat_q.
  initial begin : responder
    int cnt = 0;
    int lat = 1;
    mem_bus.mem_ack_i   = 1'b0;
    mem_bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!auto_en) begin
        cnt = 0;
        continue;
      end
      mem_bus.mem_ack_i = 1'b0;
      if (!rst_n_i) cnt = 0;
      else if (mem_bus.mem_req_o) begin
        if (cnt == 0) lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
        cnt++;
        if (cnt >= lat) begin
          mem_bus.mem_ack_i = 1'b1;
          if (mem_bus.mem_we_o) bk_mem[mem_bus.mem_addr_o] = mem_bus.mem_wdata_o;
          else mem_bus.mem_rdata_i = bk_mem.exists(mem_bus.mem_addr_o) ?
                                     bk_mem[mem_bus.mem_addr_o] : blank(mem_bus.mem_addr_o);
          cnt = 0;
        end
      end
    end
  end

  // Monitor: one scoreboard entry retires whenever stall_o falls after an access.
  initial begin : monitor
    int            stall_cnt = 0;
    int            trains    = 0;
    logic          prev_req  = 1'b0;
    logic          prev_stall = 1'b0;
    logic          cap_we    = 1'b0;
    logic [AW-1:0] cap_addr  = '0;
    logic [DW-1:0] cap_wdata = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        stall_cnt = 0; trains = 0; prev_req = 1'b0; prev_stall = 1'b0;
        continue;
      end
      if (stall_o) stall_cnt++;
      if (mem_bus.mem_req_o && !prev_req) begin
        trains++;
        cap_we    = mem_bus.mem_we_o;
        cap_addr  = mem_bus.mem_addr_o;
        cap_wdata = mem_bus.mem_wdata_o;
      end
      if (!stall_o && prev_stall) begin
        if (exp_q.size() == 0) check("pending_expect", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("stall_cycles", stall_cnt, e.stall);
          check("req_trains", trains, 1);
          check("req_low_done", mem_bus.mem_req_o, 1'b0);
          check("bus_we", cap_we, e.we);
          check("bus_addr", cap_addr, e.addr);
          if (e.we) check("bus_wdata", cap_wdata, e.wdata);
          check("readdata", Readdata_o, e.rdata);
        end
        stall_cnt = 0;
        trains    = 0;
      end
      prev_req   = mem_bus.mem_req_o;
      prev_stall = stall_o;
    end
  end

  // Issue one access at posedge+1 and hold the strobes until the DONE cycle has passed.
  task automatic do_access(input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat);
    exp_t e;
    bit   seen = 1'b0;
    bit   done = 1'b0;
    e.we    = wr;
    e.addr  = a;
    e.wdata = d;
    if (wr) ref_mem[a] = d;
    else    last_rd = ref_read(a);
    e.rdata = last_rd;
    e.stall = lat + 1;
    exp_q.push_back(e);
    lat_q.push_back(lat);
    MemRead_i   = rd;
    MemWrite_i  = wr;
    Address_i   = a;
    Writedata_i = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_o) seen = 1'b1;
      else if (seen) begin
        done = 1'b1;
        break;
      end
    end
    check("access_completes", done, 1'b1);
    @(posedge clk);
    #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin : stimulus
    rst_n_i     = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    Address_i   = '0;
    Writedata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    @(negedge clk);
    check("rst_req", mem_bus.mem_req_o, 1'b0);
    check("rst_we", mem_bus.mem_we_o, 1'b0);
    check("rst_addr", mem_bus.mem_addr_o, '0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_readdata", Readdata_o, '0);

    // Reset during BUSY, then a late ack that must be dropped.
    @(posedge clk); #1;
    MemRead_i = 1'b1;
    Address_i = 32'h10;
    @(negedge clk);
    check("t1_idle_stall", stall_o, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_busy_req", mem_bus.mem_req_o, 1'b1);
    @(posedge clk); #1;
    rst_n_i   = 1'b0;
    MemRead_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_req_after_rst", mem_bus.mem_req_o, 1'b0);
    check("t1_stall_after_rst", stall_o, 1'b0);
    check("t1_rd_after_rst", Readdata_o, '0);
    @(posedge clk); #1;
    rst_n_i             = 1'b1;
    mem_bus.mem_ack_i   = 1'b1;
    mem_bus.mem_rdata_i = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    mem_bus.mem_ack_i = 1'b0;
    @(negedge clk);
    check("t1_late_ack_req", mem_bus.mem_req_o, 1'b0);
    check("t1_late_ack_stall", stall_o, 1'b0);
    check("t1_late_ack_rd", Readdata_o, '0);

    auto_en = 1'b1;
    @(posedge clk); #1;

`ifdef WRITE_BUFFER_EN
    begin : wb_test
      int n    = 0;
      bit done = 1'b0;
      preload(32'h44, 32'hCAFE_F00D);
      lat_q.push_back(3);
      lat_q.push_back(1);
      MemWrite_i  = 1'b1;
      Address_i   = 32'h40;
      Writedata_i = 32'h5555_AAAA;
      @(negedge clk);
      check("wb_store_stall", stall_o, 1'b0);
      @(posedge clk); #1;
      MemWrite_i = 1'b0;
      MemRead_i  = 1'b1;
      Address_i  = 32'h44;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i < 3) begin
          check("wb_drain_we", mem_bus.mem_we_o, 1'b1);
          check("wb_drain_addr", mem_bus.mem_addr_o, 32'h40);
        end
        if (stall_o) n++;
        else begin
          done = 1'b1;
          break;
        end
      end
      check("wb_load_done", done, 1'b1);
      check("wb_load_stall", n, 5);
      check("wb_load_data", Readdata_o, 32'hCAFE_F00D);
      check("wb_store_landed", bk_mem.exists(32'h40) ? bk_mem[32'h40] : '0, 32'h5555_AAAA);
      @(posedge clk); #1;
      MemRead_i = 1'b0;
    end
`else
    mon_en = 1'b1;
    @(posedge clk); #1;
    preload(32'h10, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 32'h10, '0, 3);
    do_access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 1);
    // Back-to-back load then store, no idle gap.
    do_access(1'b1, 1'b0, 32'h20, '0, 2);
    do_access(1'b0, 1'b1, 32'h24, 32'h0BAD_CAFE, 4);
    do_access(1'b1, 1'b1, 32'h28, 32'h7777_0001, 2);
    do_access(1'b1, 1'b0, 32'h28, '0, 1);

    for (int k = 0; k < 150; k++) begin
      int            kind = $urandom_range(0, 9);
      logic [AW-1:0] a    = 32'h100 + {$urandom_range(0, 15), 2'b00};
      logic [DW-1:0] d    = $urandom;
      int            lat  = $urandom_range(1, 5);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if (kind < 5)      do_access(1'b1, 1'b0, a, d, lat);
      else if (kind < 9) do_access(1'b0, 1'b1, a, d, lat);
      else               do_access(1'b1, 1'b1, a, d, lat);
    end
    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_req_end", mem_bus.mem_req_o, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
